// File: rtl/mem_stream_reader_pkg.sv
// mem_stream_reader_pkg: shared types and sizes for the memory stream reader and its skid FIFO
package mem_stream_reader_pkg;
  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int SKID_IDX_W = $clog2(SKID_DEPTH);
  localparam int STREAM_DATA_W = 64;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} reader_state_e;
  typedef struct packed {
    logic [STREAM_DATA_W-1:0] data;
    logic                     last;
  } stream_word_t;
endpackage

// File: rtl/mem_stream_reader_if.sv
// mem_stream_reader_if: command, memory read port and output stream of one reader
interface mem_stream_reader_if #(
  parameter int MEM_WIDTH_BYTES = 8,
  parameter int MEM_DEPTH = 256
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int DW = MEM_WIDTH_BYTES * 8;
  logic          start_in;
  logic [AW-1:0] base_addr_in;
  logic [AW:0]   len_in;
  logic          busy_out;
  logic          done_out;
  logic [AW-1:0] mem_read_addr_out;
  logic          mem_read_out;
  logic [DW-1:0] mem_read_data_in;
  logic          out_valid_out;
  logic [DW-1:0] out_data_out;
  logic          out_last_out;
  logic          out_ready_in;
  logic          debugen_in;
  modport master (
    input  start_in, base_addr_in, len_in, mem_read_data_in, out_ready_in, debugen_in,
    output busy_out, done_out, mem_read_addr_out, mem_read_out, out_valid_out, out_data_out, out_last_out
  );
  modport slave (
    output start_in, base_addr_in, len_in, mem_read_data_in, out_ready_in, debugen_in,
    input  busy_out, done_out, mem_read_addr_out, mem_read_out, out_valid_out, out_data_out, out_last_out
  );
endinterface

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: small first-word-fall-through FIFO of stream words, head is always visible
module stream_skid_fifo
  import mem_stream_reader_pkg::*;
#(
  parameter type word_t = stream_word_t
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  word_t                 push_word,
  input  logic                  pop,
  output word_t                 head,
  output logic                  valid,
  output logic [SKID_CNT_W-1:0] count
);
  word_t q [SKID_DEPTH];
  logic pop_e;
  logic [SKID_IDX_W-1:0] slot;
  assign valid = count != '0;
  assign head = q[0];
  assign pop_e = pop && valid;
  // a push lands behind whatever survives this cycle's pop
  assign slot = SKID_IDX_W'(count - SKID_CNT_W'(pop_e));
  always_ff @(posedge clk)
    if (!reset) begin
      q <= '{default: '0};
      count <= '0;
    end else begin
      if (pop_e) for (int i = 0; i < SKID_DEPTH - 1; i++) q[i] <= q[i + 1];
      if (push) q[slot] <= push_word;
      count <= count + SKID_CNT_W'(push) - SKID_CNT_W'(pop_e);
    end
endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: reads a run of consecutive memory words and streams them out with a last marker
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int MEM_WIDTH_BYTES = 8,
  parameter int MEM_DEPTH = 256,
  parameter bit SHOWAHEAD = 0
) (
  input logic clk,
  input logic reset,
  mem_stream_reader_if.master bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int DW = MEM_WIDTH_BYTES * 8;
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;
  reader_state_e state, state_nx;
  logic [AW-1:0] addr, addr_nx;
  logic [AW:0] rem, rem_nx, len_c;
  logic done_q, done_nx, pend, pend_last, credit, issue, final_rd, push, pop, head_valid;
  logic [SKID_CNT_W-1:0] cnt;
  word_t head, push_word;
  assign len_c = bus.len_in > (AW+1)'(MEM_DEPTH) ? (AW+1)'(MEM_DEPTH) : bus.len_in;
  assign pop = head_valid && bus.out_ready_in;
  // a word leaving this cycle frees its slot for a read issued in the same cycle
  assign credit = int'(cnt) + int'(pend) - int'(pop) < SKID_DEPTH;
  assign issue = state == READ && credit;
  assign final_rd = rem == (AW+1)'(1);
  assign push = SHOWAHEAD ? issue : pend;
  assign push_word = '{data: bus.mem_read_data_in, last: SHOWAHEAD ? final_rd : pend_last};
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      done_q <= 1'b0;
      pend <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      state <= state_nx;
      addr <= addr_nx;
      rem <= rem_nx;
      done_q <= done_nx;
      pend <= !SHOWAHEAD && issue;
      pend_last <= final_rd;
    end
  always_comb begin
    state_nx = state;
    addr_nx = addr;
    rem_nx = rem;
    done_nx = 1'b0;
    case (state)
      IDLE: if (bus.start_in) begin
        done_nx = len_c == '0;
        state_nx = len_c == '0 ? IDLE : READ;
        addr_nx = bus.base_addr_in;
        rem_nx = len_c;
      end
      READ: if (issue) begin
        addr_nx = addr + 1'b1;
        rem_nx = rem - 1'b1;
        state_nx = final_rd ? DRAIN : READ;
      end
      DRAIN: if (pop && head.last) begin
        state_nx = IDLE;
        done_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  stream_skid_fifo #(.word_t(word_t)) u_fifo (
    .clk,
    .reset,
    .push,
    .push_word,
    .pop,
    .head,
    .valid(head_valid),
    .count(cnt)
  );
  assign bus.busy_out = state != IDLE;
  assign bus.done_out = done_q;
  assign bus.mem_read_out = issue;
  assign bus.mem_read_addr_out = addr;
  assign bus.out_valid_out = head_valid;
  assign bus.out_data_out = head_valid ? head.data : '0;
  assign bus.out_last_out = head_valid && head.last;
`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (reset && bus.debugen_in)
      $write("%0t msr st=%s start=%b len=%0d rd=%b ra=%h v=%b r=%b d=%h l=%b done=%b\n", $time, state.name(),
             bus.start_in, bus.len_in, issue, addr, head_valid, bus.out_ready_in, bus.out_data_out,
             bus.out_last_out, done_q);
`endif
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: scoreboard bench running a registered-read and a show-ahead reader side by side
module tb_mem_stream_reader;
  localparam int D = 256;
  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [63:0] mem [D];
  logic start [2];
  logic ready [2];
  logic [7:0] base [2];
  logic [8:0] len [2];
  logic busy [2], done [2], mread [2], valid [2], last [2], full_push [2];
  logic [7:0] maddr [2];
  logic [63:0] data [2];
  logic [7:0] aq [2][$];
  exp_t wq [2][$];
  int outst [2];
  logic pv [2], pr [2], pl [2];
  logic [63:0] pd [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g
    mem_stream_reader_if #(.MEM_WIDTH_BYTES(8), .MEM_DEPTH(D)) bus ();
    logic [63:0] rd;
    mem_stream_reader #(.MEM_WIDTH_BYTES(8), .MEM_DEPTH(D), .SHOWAHEAD(k == 1)) dut (.clk, .reset, .bus);
    if (k == 0) begin : reg_rd
      always @(posedge clk) if (bus.mem_read_out) rd <= mem[bus.mem_read_addr_out];
    end else begin : sa_rd
      assign rd = mem[bus.mem_read_addr_out];
    end
    assign bus.mem_read_data_in = rd;
    assign bus.start_in = start[k];
    assign bus.base_addr_in = base[k];
    assign bus.len_in = len[k];
    assign bus.out_ready_in = ready[k];
    assign bus.debugen_in = 1'b0;
    assign busy[k] = bus.busy_out;
    assign done[k] = bus.done_out;
    assign mread[k] = bus.mem_read_out;
    assign maddr[k] = bus.mem_read_addr_out;
    assign valid[k] = bus.out_valid_out;
    assign data[k] = bus.out_data_out;
    assign last[k] = bus.out_last_out;
    assign full_push[k] = dut.push && dut.cnt == 2'd2 && !dut.pop;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    start[1] = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic cmd(input int k, input int b, input int n);
    int m;
    logic [7:0] a;
    m = n > D ? D : n;
    start[k] = 1'b1;
    base[k] = 8'(b);
    len[k] = 9'(n);
    for (int j = 0; j < m; j++) begin
      a = 8'(b + j);
      aq[k].push_back(a);
      wq[k].push_back('{d: mem[a], l: j == m - 1});
    end
  endtask

  task automatic chk_zero(input int k);
    chk($sformatf("rst_busy%0d", k), busy[k], 0);
    chk($sformatf("rst_done%0d", k), done[k], 0);
    chk($sformatf("rst_mread%0d", k), mread[k], 0);
    chk($sformatf("rst_valid%0d", k), valid[k], 0);
    chk($sformatf("rst_last%0d", k), last[k], 0);
    chk($sformatf("rst_data%0d", k), data[k], 0);
    chk($sformatf("rst_addr%0d", k), maddr[k], 0);
  endtask

  task automatic chk_empty(input int k);
    chk($sformatf("reads_left%0d", k), aq[k].size(), 0);
    chk($sformatf("words_left%0d", k), wq[k].size(), 0);
  endtask

  task automatic wait_done(input int k, input int budget);
    int n = 0;
    do begin
      next();
      mid();
      n++;
    end while (!done[k] && n < budget);
    chk($sformatf("done_timeout%0d", k), done[k], 1);
    chk($sformatf("busy_at_done%0d", k), busy[k], 0);
    next();
    mid();
    chk($sformatf("done_pulse%0d", k), done[k], 0);
    chk_empty(k);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!reset) begin
          aq[k].delete();
          wq[k].delete();
          outst[k] = 0;
          pv[k] = 1'b0;
        end else begin
          chk($sformatf("occupancy%0d", k), outst[k] <= 2, 1);
          chk($sformatf("full_push%0d", k), full_push[k], 0);
          if (mread[k]) begin
            chk($sformatf("credit%0d", k), outst[k] - int'(valid[k] && ready[k]) < 2, 1);
            chk($sformatf("read_expected%0d", k), aq[k].size() != 0, 1);
            if (aq[k].size() != 0) chk($sformatf("read_addr%0d", k), maddr[k], aq[k].pop_front());
          end
          if (pv[k] && !pr[k]) begin
            chk($sformatf("hold_valid%0d", k), valid[k], 1);
            chk($sformatf("hold_data%0d", k), data[k], pd[k]);
            chk($sformatf("hold_last%0d", k), last[k], pl[k]);
          end
          if (valid[k] && ready[k]) begin
            chk($sformatf("word_expected%0d", k), wq[k].size() != 0, 1);
            if (wq[k].size() != 0) begin
              e = wq[k].pop_front();
              chk($sformatf("word_data%0d", k), data[k], e.d);
              chk($sformatf("word_last%0d", k), last[k], e.l);
            end
          end
          outst[k] += int'(mread[k]) - int'(valid[k] && ready[k]);
          pv[k] = valid[k];
          pr[k] = ready[k];
          pd[k] = data[k];
          pl[k] = last[k];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] e_rd, e_v, e_l, e_b, e_d;
    logic [7:0] pat;
    int hs, n;
    bit seen0, seen1;
    for (int i = 0; i < D; i++) mem[i] = 64'(i);
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0;
      ready[k] = 1'b1;
      base[k] = '0;
      len[k] = '0;
    end
    repeat (3) next();
    mid();
    chk_zero(0);
    chk_zero(1);
    next();
    reset = 1'b1;

    next();
    cmd(0, 4, 3);
    e_rd = 7'b0000111;
    e_v = 7'b0011100;
    e_l = 7'b0010000;
    e_b = 7'b0011111;
    e_d = 7'b0100000;
    for (int i = 0; i < 7; i++) begin
      next();
      mid();
      chk($sformatf("t1_mread_c%0d", i + 1), mread[0], e_rd[i]);
      chk($sformatf("t1_valid_c%0d", i + 1), valid[0], e_v[i]);
      chk($sformatf("t1_last_c%0d", i + 1), last[0], e_l[i]);
      chk($sformatf("t1_busy_c%0d", i + 1), busy[0], e_b[i]);
      chk($sformatf("t1_done_c%0d", i + 1), done[0], e_d[i]);
    end
    chk_empty(0);

    next();
    cmd(0, 254, 4);
    wait_done(0, 20);

    next();
    cmd(0, 7, 0);
    next();
    mid();
    chk("len0_done", done[0], 1);
    chk("len0_busy", busy[0], 0);
    chk("len0_valid", valid[0], 0);
    chk("len0_mread", mread[0], 0);
    next();
    mid();
    chk("len0_done_off", done[0], 0);
    chk("len0_busy_off", busy[0], 0);
    chk("len0_valid_off", valid[0], 0);

    pat = 8'b11101001;
    next();
    cmd(0, 100, 5);
    cmd(1, 100, 5);
    n = 0;
    seen0 = 1'b0;
    seen1 = 1'b0;
    do begin
      next();
      ready[0] = n < 8 ? pat[n] : 1'b1;
      ready[1] = ready[0];
      mid();
      seen0 |= done[0];
      seen1 |= done[1];
      n++;
    end while (!(seen0 && seen1) && n < 40);
    chk("bp_done0", seen0, 1);
    chk("bp_done1", seen1, 1);
    ready[0] = 1'b1;
    ready[1] = 1'b1;
    chk_empty(0);
    chk_empty(1);

    next();
    cmd(0, 5, 256);
    wait_done(0, 300);
    next();
    cmd(0, 200, 300);
    wait_done(0, 300);

    next();
    cmd(0, 0, 8);
    hs = 0;
    n = 0;
    do begin
      next();
      mid();
      if (valid[0] && ready[0]) hs++;
      n++;
    end while (hs < 3 && n < 20);
    chk("rst_handshakes", hs, 3);
    next();
    reset = 1'b0;
    next();
    reset = 1'b1;
    mid();
    chk_zero(0);
    next();
    mid();
    chk("rst_no_done", done[0], 0);
    chk("rst_idle", busy[0], 0);
    next();
    cmd(0, 0, 2);
    wait_done(0, 20);

    next();
    cmd(1, 10, 2);
    next();
    mid();
    chk("sa_c1_valid", valid[1], 0);
    chk("sa_c1_busy", busy[1], 1);
    chk("sa_c1_mread", mread[1], 1);
    next();
    mid();
    chk("sa_c2_valid", valid[1], 1);
    chk("sa_c2_last", last[1], 0);
    next();
    mid();
    chk("sa_c3_valid", valid[1], 1);
    chk("sa_c3_last", last[1], 1);
    next();
    chk("sa_done_a", done[1], 1);
    cmd(1, 20, 1);
    next();
    mid();
    chk("sa_b_busy", busy[1], 1);
    chk("sa_b_done_off", done[1], 0);
    chk("sa_b_c1_valid", valid[1], 0);
    chk("sa_b_c1_mread", mread[1], 1);
    next();
    mid();
    chk("sa_b_c2_valid", valid[1], 1);
    chk("sa_b_c2_last", last[1], 1);
    chk("sa_b_c2_data", data[1], 64'd20);
    next();
    mid();
    chk("sa_done_b", done[1], 1);
    chk("sa_b_busy_off", busy[1], 0);
    next();
    mid();
    chk("sa_done_b_off", done[1], 0);
    chk_empty(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
